// File: rtl/mod3_arbiter.sv
// Round-robin arbiter sharing one serial 2-bit-per-cycle mod-3 reducer.
// Define MOD3_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module mod3_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  e,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] x,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [1:0]            s,
  output logic [IDW-1:0]        id,
  output logic                  f
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [1:0]       acc;
  logic [CW-1:0]    cnt;
  logic [IDW-1:0]   idp;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   idx;
  logic             hit;
  logic [WIDTH-1:0] op;
  logic [2:0]       sum;
  logic [1:0]       nxt;
`ifndef MOD3_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr;
`endif

  always_comb begin
    pick = '0;
    idx  = '0;
    hit  = 1'b0;
`ifdef MOD3_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'(i);
      if (req[idx]) begin
        pick = idx;
        hit  = 1'b1;
      end
    end
`else
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!hit && req[idx]) begin
        pick = idx;
        hit  = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    op = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == IDW'(k)) op = x[k*WIDTH +: WIDTH];
    end
  end

  // acc + digit is at most 5, so one subtraction of 3 lands in 0..2
  always_comb begin
    sum = {1'b0, acc} + {1'b0, sh[1:0]};
    nxt = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
      s     <= 2'd0;
      id    <= '0;
      f     <= 1'b0;
      cnt   <= '0;
      acc   <= 2'd0;
      sh    <= '0;
      idp   <= '0;
`ifndef MOD3_ARB_FIXED_PRIO_EN
      ptr   <= IDW'(NREQ - 1);
`endif
    end else begin
      unique case (state)
        IDLE: begin
          f   <= 1'b0;
          gnt <= '0;
          if (e && hit) begin
            sh    <= op;
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            idp   <= pick;
`ifndef MOD3_ARB_FIXED_PRIO_EN
            ptr   <= pick;
`endif
            acc   <= 2'd0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          gnt <= '0;
          acc <= nxt;
          sh  <= sh >> 2;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(STEPS - 1)) begin
            s     <= nxt;
            id    <= idp;
            f     <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod3_arbiter.sv
// Bench for mod3_arbiter: directed scenarios plus randomized traffic
// checked against an arithmetic residue / arbitration model.
module tb_mod3_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 64;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  e;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] x;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [1:0]            s;
  logic [IDW-1:0]        id;
  logic                  f;

  int checks = 0;
  int errors = 0;
  int mptr;

  mod3_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .e(e), .req(req), .x(x),
    .gnt(gnt), .busy(busy), .s(s), .id(id), .f(f)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef MOD3_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int i = 1; i <= NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
`endif
    return -1;
  endfunction

  function automatic logic [1:0] res3(input logic [WIDTH-1:0] v);
    return 2'(v % 3);
  endfunction

  task automatic chk_grant(input int k);
    chk("gnt", 64'(gnt), 64'(1) << k);
    chk("busy_on_grant", 64'(busy), 64'd1);
    chk("f_off_on_grant", 64'(f), 64'd0);
    mptr = k;
  endtask

  task automatic finish_op(input int k, input logic [1:0] sx);
    tick;
    chk("gnt_pulse_end", 64'(gnt), 64'd0);
    chk("busy_mid", 64'(busy), 64'd1);
    repeat (WIDTH/2 - 2) tick;
    chk("f_not_early", 64'(f), 64'd0);
    chk("busy_late", 64'(busy), 64'd1);
    tick;
    chk("f_done", 64'(f), 64'd1);
    chk("s", 64'(s), 64'(sx));
    chk("id", 64'(id), 64'(k));
    chk("busy_done", 64'(busy), 64'd0);
    chk("gnt_at_done", 64'(gnt), 64'd0);
  endtask

  initial begin
    int k;
    logic [NREQ-1:0]  r;
    logic [WIDTH-1:0] opv;

    rst_n = 1'b0;
    e     = 1'b0;
    req   = '0;
    x     = '0;
    mptr  = NREQ - 1;
    #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_id", 64'(id), 64'd0);
    chk("rst_f", 64'(f), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single operand
    e = 1'b1;
    x[0*WIDTH +: WIDTH] = 64'h7;
    req = 4'b0001;
    tick;
    chk_grant(pick(4'b0001, mptr));
    req = '0;
    finish_op(0, 2'd1);

    // residues on requester 2
    foreach (opv[i]) opv[i] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      opv = (t == 0) ? 64'h3 : (t == 1) ? 64'h5 : 64'hFFFF_FFFF_FFFF_FFFF;
      x[2*WIDTH +: WIDTH] = opv;
      req = 4'b0100;
      tick;
      k = pick(4'b0100, mptr);
      chk_grant(k);
      req = '0;
      finish_op(k, res3(opv));
    end

    // fairness from a fresh pointer with all requests held
    rst_n = 1'b0;
    tick;
    mptr = NREQ - 1;
    rst_n = 1'b1;
    for (int j = 0; j < NREQ; j++) x[j*WIDTH +: WIDTH] = WIDTH'(j + 10);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick;
      k = pick(4'b1111, mptr);
      chk_grant(k);
      finish_op(k, res3(x[k*WIDTH +: WIDTH]));
    end

    // enable gating
    e = 1'b0;
    req = 4'b0100;
    x[2*WIDTH +: WIDTH] = 64'h7;
    repeat (3) begin
      tick;
      chk("gated_gnt", 64'(gnt), 64'd0);
      chk("gated_busy", 64'(busy), 64'd0);
    end
    e = 1'b1;
    tick;
    chk_grant(pick(4'b0100, mptr));
    req = '0;
    e = 1'b0;
    finish_op(2, 2'd1);

    // async reset mid-operation
    e = 1'b1;
    x[2*WIDTH +: WIDTH] = 64'h5;
    req = 4'b0100;
    tick;
    chk_grant(pick(4'b0100, mptr));
    req = '0;
    repeat (9) tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_s", 64'(s), 64'd0);
    chk("mid_rst_id", 64'(id), 64'd0);
    chk("mid_rst_f", 64'(f), 64'd0);
    mptr = NREQ - 1;
    repeat (2) tick;
    rst_n = 1'b1;
    for (int t = 0; t < WIDTH/2 + 2; t++) begin
      tick;
      chk("no_f_after_rst", 64'(f), 64'd0);
    end
    x[1*WIDTH +: WIDTH] = 64'h8;
    x[3*WIDTH +: WIDTH] = 64'h9;
    req = 4'b1010;
    tick;
    k = pick(4'b1010, mptr);
    chk_grant(k);
    req = '0;
    finish_op(k, res3(x[k*WIDTH +: WIDTH]));

    // operand stability after grant
    x[0*WIDTH +: WIDTH] = 64'h5;
    req = 4'b0001;
    tick;
    chk_grant(pick(4'b0001, mptr));
    x[0*WIDTH +: WIDTH] = 64'h0;
    req = '0;
    finish_op(0, 2'd2);

    // randomized traffic; x and req scrambled while busy
    for (int t = 0; t < 25; t++) begin
      r = NREQ'($urandom_range(0, 15));
      for (int j = 0; j < NREQ; j++)
        x[j*WIDTH +: WIDTH] = {$urandom, $urandom};
      req = r;
      tick;
      if (r == '0) begin
        chk("rand_idle_gnt", 64'(gnt), 64'd0);
        chk("rand_idle_busy", 64'(busy), 64'd0);
      end else begin
        k = pick(r, mptr);
        opv = x[k*WIDTH +: WIDTH];
        chk_grant(k);
        for (int j = 0; j < NREQ; j++)
          x[j*WIDTH +: WIDTH] = {$urandom, $urandom};
        req = NREQ'($urandom_range(0, 15));
        finish_op(k, res3(opv));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
